// File: rtl/cim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cim_ctrl
// Brief    : Ready/valid CIM command controller. Sequences one command at a
//            time into an array of fixed-latency compute-in-memory macros and
//            accumulates compute results into a bank of accumulator registers.
// Revision : 1.0 - initial release
// ============================================================================
module cim_ctrl #(
   parameter int NBANK = 4,
   parameter int NREG  = 16,
   parameter int ACCW  = 32,
   parameter int LAT   = 3,
   parameter int ROWW  = 8,
   parameter int SAT   = 1
) (
   input  logic                     CLK,
   input  logic                     RESN,
   input  logic                     CMD_VALID,
   output logic                     CMD_READY,
   input  logic [2:0]               CMD_OP,
   input  logic [31:0]              CMD_ADDR,
   input  logic [31:0]              CMD_DATA,
   input  logic [$clog2(NREG)-1:0]  CMD_REG,
   output logic                     RSP_VALID,
   output logic [31:0]              RSP_DATA,
   output logic                     RSP_ERR,
   output logic [NBANK-1:0]         MAC_EN,
   output logic                     MAC_WE,
   output logic                     MAC_COMP,
   output logic [ROWW-1:0]          MAC_ADDR,
   output logic [31:0]              MAC_WDATA,
   input  logic [32*NBANK-1:0]      MAC_RDATA
);

   localparam int BW = $clog2(NBANK);
   localparam int RW = $clog2(NREG);
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [2:0] OP_WR     = 3'd0;
   localparam logic [2:0] OP_COMP   = 3'd1;
   localparam logic [2:0] OP_RD     = 3'd2;
   localparam logic [2:0] OP_REGRD  = 3'd3;
   localparam logic [2:0] OP_REGRST = 3'd4;

   localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
   localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q;
   logic [2:0]        op_q;
   logic [BW-1:0]     bank_q;
   logic [RW-1:0]     reg_q;
   logic              clr_all_q;
   logic [CW-1:0]     cnt_q;
   logic [ACCW-1:0]   acc_q [NREG];

   logic              ready_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_data_q;
   logic              rsp_err_q;
   logic [NBANK-1:0]  mac_en_q;
   logic              mac_we_q;
   logic              mac_comp_q;
   logic [ROWW-1:0]   mac_addr_q;
   logic [31:0]       mac_wdata_q;

   logic [31:0]       slice_d;
   logic [ACCW-1:0]   acc_cur_d;
   logic [ACCW:0]     sum_d;
   logic [ACCW-1:0]   acc_d;
   logic [31:0]       rdval_d;
   logic              unused_addr_d;

   // Address bits above the bank field carry no meaning for this controller.
   assign unused_addr_d = ^{CMD_ADDR[31:ROWW+BW], CMD_DATA[31:1]};

   // Accumulate datapath: widen by one bit so overflow is visible, then clamp or wrap.
   always_comb begin
      slice_d   = MAC_RDATA[{bank_q, 5'd0} +: 32];
      acc_cur_d = acc_q[reg_q];
      sum_d     = {acc_cur_d[ACCW-1], acc_cur_d} + {{(ACCW+1-32){slice_d[31]}}, slice_d};
      acc_d     = sum_d[ACCW-1:0];
      if ((SAT != 0) && (sum_d[ACCW] != sum_d[ACCW-1])) begin
         acc_d = sum_d[ACCW] ? ACC_MIN : ACC_MAX;
      end
      // Register readback narrows to 32 bits; with saturation on, clamp rather than truncate.
      rdval_d = acc_cur_d[31:0];
      if ((SAT != 0) && !((&acc_cur_d[ACCW-1:31]) || !(|acc_cur_d[ACCW-1:31]))) begin
         rdval_d = acc_cur_d[ACCW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   // Command FSM with registered outputs and the accumulator file.
   always_ff @(posedge CLK) begin
      if (!RESN) begin
         state_q     <= S_IDLE;
         op_q        <= 3'd0;
         bank_q      <= '0;
         reg_q       <= '0;
         clr_all_q   <= 1'b0;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_err_q   <= 1'b0;
         mac_en_q    <= '0;
         mac_we_q    <= 1'b0;
         mac_comp_q  <= 1'b0;
         mac_addr_q  <= '0;
         mac_wdata_q <= 32'd0;
         for (int i = 0; i < NREG; i++) acc_q[i] <= '0;
      end else begin
         // Strobes and macro drive are single-cycle unless re-asserted below.
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_err_q   <= 1'b0;
         mac_en_q    <= '0;
         mac_we_q    <= 1'b0;
         mac_comp_q  <= 1'b0;
         mac_addr_q  <= '0;
         mac_wdata_q <= 32'd0;
         case (state_q)
            S_IDLE: begin
               if (CMD_VALID && ready_q) begin
                  op_q      <= CMD_OP;
                  bank_q    <= CMD_ADDR[ROWW +: BW];
                  reg_q     <= CMD_REG;
                  clr_all_q <= CMD_DATA[0];
                  ready_q   <= 1'b0;
                  state_q   <= S_ISSUE;
                  // Macro drive is registered here so it is visible during ISSUE.
                  if (CMD_OP <= OP_RD) begin
                     mac_en_q    <= {{(NBANK-1){1'b0}}, 1'b1} << CMD_ADDR[ROWW +: BW];
                     mac_we_q    <= (CMD_OP == OP_WR);
                     mac_comp_q  <= (CMD_OP == OP_COMP);
                     mac_addr_q  <= CMD_ADDR[ROWW-1:0];
                     mac_wdata_q <= CMD_DATA;
                  end
               end
            end
            S_ISSUE: begin
               if ((op_q == OP_COMP) || (op_q == OP_RD)) begin
                  cnt_q   <= CW'(LAT - 1);
                  state_q <= S_WAIT;
               end else begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= (op_q > OP_REGRST);
                  if (op_q == OP_REGRD) rsp_data_q <= rdval_d;
                  if (op_q == OP_REGRST) begin
                     if (clr_all_q) begin
                        for (int i = 0; i < NREG; i++) acc_q[i] <= '0;
                     end else begin
                        acc_q[reg_q] <= '0;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  if (op_q == OP_COMP) begin
                     acc_q[reg_q] <= acc_d;
                     rsp_data_q   <= acc_d[31:0];
                  end else begin
                     rsp_data_q   <= slice_d;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign CMD_READY = ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_ERR   = rsp_err_q;
   assign MAC_EN    = mac_en_q;
   assign MAC_WE    = mac_we_q;
   assign MAC_COMP  = mac_comp_q;
   assign MAC_ADDR  = mac_addr_q;
   assign MAC_WDATA = mac_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cim_ctrl
// Brief    : Self-checking bench for cim_ctrl. Runs a saturating and a
//            wrapping instance in lockstep against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cim_ctrl;

   localparam int NBANK = 4;
   localparam int NREG  = 16;
   localparam int ACCW  = 32;
   localparam int LAT   = 3;
   localparam int ROWW  = 8;

   logic         clk = 1'b0;
   logic         resn;
   logic         cmd_valid;
   logic [2:0]   cmd_op;
   logic [31:0]  cmd_addr;
   logic [31:0]  cmd_data;
   logic [3:0]   cmd_reg;
   logic [127:0] mac_rdata;

   logic         ready_s, rsp_valid_s, rsp_err_s, mac_we_s, mac_comp_s;
   logic [31:0]  rsp_data_s, mac_wdata_s;
   logic [3:0]   mac_en_s;
   logic [7:0]   mac_addr_s;
   logic         ready_w, rsp_valid_w, rsp_err_w, mac_we_w, mac_comp_w;
   logic [31:0]  rsp_data_w, mac_wdata_w;
   logic [3:0]   mac_en_w;
   logic [7:0]   mac_addr_w;

   // Behavioural model state
   longint       acc_s [NREG];
   longint       acc_w [NREG];
   logic [31:0]  mem [NBANK][256];
   int           pass_cnt  = 0;
   int           total_cnt = 0;

   always #5 clk = ~clk;

   cim_ctrl #(.NBANK(NBANK), .NREG(NREG), .ACCW(ACCW), .LAT(LAT), .ROWW(ROWW), .SAT(1)) u_sat (
      .CLK(clk), .RESN(resn), .CMD_VALID(cmd_valid), .CMD_READY(ready_s),
      .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .CMD_REG(cmd_reg),
      .RSP_VALID(rsp_valid_s), .RSP_DATA(rsp_data_s), .RSP_ERR(rsp_err_s),
      .MAC_EN(mac_en_s), .MAC_WE(mac_we_s), .MAC_COMP(mac_comp_s),
      .MAC_ADDR(mac_addr_s), .MAC_WDATA(mac_wdata_s), .MAC_RDATA(mac_rdata)
   );

   cim_ctrl #(.NBANK(NBANK), .NREG(NREG), .ACCW(ACCW), .LAT(LAT), .ROWW(ROWW), .SAT(0)) u_wrap (
      .CLK(clk), .RESN(resn), .CMD_VALID(cmd_valid), .CMD_READY(ready_w),
      .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .CMD_REG(cmd_reg),
      .RSP_VALID(rsp_valid_w), .RSP_DATA(rsp_data_w), .RSP_ERR(rsp_err_w),
      .MAC_EN(mac_en_w), .MAC_WE(mac_we_w), .MAC_COMP(mac_comp_w),
      .MAC_ADDR(mac_addr_w), .MAC_WDATA(mac_wdata_w), .MAC_RDATA(mac_rdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint clamp32(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic logic [127:0] junk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         acc_s[i] = 0;
         acc_w[i] = 0;
      end
   endtask

   // One complete transaction: present, check ISSUE drive, walk to the response.
   task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] rg, input logic [31:0] slice,
                         output logic [31:0] obs_s, output logic [31:0] obs_w);
      int          bank, row, exp_cyc;
      bit          mac_op, waits, exp_err;
      logic [31:0] es, ew, drv;
      longint      sx;
      bank    = int'(addr[9:8]);
      row     = int'(addr[7:0]);
      mac_op  = (op <= 3'd2);
      waits   = (op == 3'd1) || (op == 3'd2);
      exp_cyc = waits ? LAT + 2 : 2;
      exp_err = (op > 3'd4);
      es = 32'd0; ew = 32'd0; drv = slice;
      sx = longint'($signed(slice));
      case (op)
         3'd0: mem[bank][row] = data;
         3'd1: begin
            acc_s[rg] = clamp32(acc_s[rg] + sx);
            acc_w[rg] = longint'(int'(acc_w[rg] + sx));
            es = acc_s[rg][31:0];
            ew = acc_w[rg][31:0];
         end
         3'd2: begin
            drv = mem[bank][row];
            es  = drv;
            ew  = drv;
         end
         3'd3: begin
            es = clamp32(acc_s[rg]) & 64'hFFFF_FFFF;
            ew = acc_w[rg][31:0];
         end
         3'd4: begin
            for (int i = 0; i < NREG; i++) begin
               if (data[0] || (i == int'(rg))) begin
                  acc_s[i] = 0;
                  acc_w[i] = 0;
               end
            end
         end
         default: ;
      endcase
      obs_s = 32'hx; obs_w = 32'hx;

      @(negedge clk);
      check("ready_idle_s", ready_s, 1);
      check("ready_idle_w", ready_w, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_reg = rg;
      mac_rdata = junk();

      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_addr = $urandom; cmd_data = $urandom;
      cmd_reg = 4'($urandom);
      mac_rdata = junk();
      check("issue_en", mac_en_s, mac_op ? (64'd1 << bank) : 64'd0);
      check("issue_en_w", mac_en_w, mac_op ? (64'd1 << bank) : 64'd0);
      check("issue_we", mac_we_s, op == 3'd0);
      check("issue_comp", mac_comp_s, op == 3'd1);
      check("issue_ready", ready_s, 0);
      check("issue_rspv", rsp_valid_s, 0);
      if (mac_op) begin
         check("issue_addr", mac_addr_s, addr[7:0]);
         check("issue_wdata", mac_wdata_s, data);
      end

      for (int k = 2; k <= exp_cyc; k++) begin
         @(negedge clk);
         mac_rdata = junk();
         if (waits && (k == LAT + 1)) mac_rdata[32*bank +: 32] = drv;
         check("rsp_valid_s", rsp_valid_s, k == exp_cyc);
         check("rsp_valid_w", rsp_valid_w, k == exp_cyc);
         check("mac_idle", {mac_en_s, mac_we_s, mac_comp_s, mac_en_w}, 0);
         check("busy_ready", ready_s, 0);
         if (k == exp_cyc) begin
            obs_s = rsp_data_s;
            obs_w = rsp_data_w;
            check("rsp_data_s", rsp_data_s, es);
            check("rsp_data_w", rsp_data_w, ew);
            check("rsp_err_s", rsp_err_s, exp_err);
            check("rsp_err_w", rsp_err_w, exp_err);
         end
      end
   endtask

   logic [31:0] os, ow;

   initial begin
      for (int b = 0; b < NBANK; b++)
         for (int r = 0; r < 256; r++) mem[b][r] = 32'd0;
      model_reset();
      resn = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 32'd0;
      cmd_data = 32'd0; cmd_reg = 4'd0; mac_rdata = 128'd0;

      // Reset: held two cycles, then every output at its reset value
      repeat (2) @(negedge clk);
      resn = 1'b1;
      @(negedge clk);
      check("rst_ready", {ready_s, ready_w}, 2'b11);
      check("rst_rsp", {rsp_valid_s, rsp_err_s, rsp_data_s, rsp_valid_w, rsp_err_w, rsp_data_w}, 0);
      check("rst_mac", {mac_en_s, mac_we_s, mac_comp_s, mac_addr_s, mac_wdata_s}, 0);
      check("rst_mac_w", {mac_en_w, mac_we_w, mac_comp_w, mac_addr_w, mac_wdata_w}, 0);
      do_cmd(3'd3, 32'd0, 32'd0, 4'd5, 32'd0, os, ow);
      check("rst_regrd5", os, 32'd0);

      // WR then RD of bank 1 row 3
      do_cmd(3'd0, 32'h0000_0103, 32'hDEAD_BEEF, 4'd0, 32'd0, os, ow);
      do_cmd(3'd2, 32'h0000_0103, 32'd0, 4'd0, 32'd0, os, ow);
      check("rd_const", os, 32'hDEAD_BEEF);

      // COMP accumulate into reg 2, other register untouched by its reset
      do_cmd(3'd1, 32'h0000_0205, 32'd0, 4'd3, 32'd55, os, ow);
      do_cmd(3'd1, 32'h0000_0205, 32'd0, 4'd2, 32'd100, os, ow);
      check("comp1_const", os, 32'd100);
      do_cmd(3'd1, 32'h0000_0306, 32'd0, 4'd2, -32'sd30, os, ow);
      check("comp2_const", os, 32'd70);
      do_cmd(3'd3, 32'd0, 32'd0, 4'd2, 32'd0, os, ow);
      check("regrd2_const", os, 32'd70);
      do_cmd(3'd4, 32'd0, 32'd0, 4'd2, 32'd0, os, ow);
      do_cmd(3'd3, 32'd0, 32'd0, 4'd2, 32'd0, os, ow);
      check("regrd2_clr", os, 32'd0);
      do_cmd(3'd3, 32'd0, 32'd0, 4'd3, 32'd0, os, ow);
      check("regrd3_kept", os, 32'd55);

      // Saturation boundary on reg 0
      do_cmd(3'd4, 32'd0, 32'd0, 4'd0, 32'd0, os, ow);
      do_cmd(3'd1, 32'h0000_0001, 32'd0, 4'd0, 32'h7FFF_FFF0, os, ow);
      do_cmd(3'd1, 32'h0000_0101, 32'd0, 4'd0, 32'h0000_0020, os, ow);
      check("sat_const", os, 32'h7FFF_FFFF);
      check("wrap_const", ow, 32'h8000_0010);

      // Illegal op, then clear-all
      do_cmd(3'd6, 32'h0000_0203, 32'h1234_5678, 4'd1, 32'd0, os, ow);
      do_cmd(3'd1, 32'h0000_0002, 32'd0, 4'd9, 32'd77, os, ow);
      do_cmd(3'd4, 32'd0, 32'd1, 4'd4, 32'd0, os, ow);
      for (int i = 0; i < NREG; i++) begin
         do_cmd(3'd3, 32'd0, 32'd0, 4'(i), 32'd0, os, ow);
         check("clrall_s", os, 32'd0);
         check("clrall_w", ow, 32'd0);
      end

      // Reset during WAIT of a COMP: no response, result discarded
      do_cmd(3'd1, 32'h0000_0204, 32'd0, 4'd7, 32'd500, os, ow);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 32'h0000_0204; cmd_reg = 4'd7; cmd_data = 32'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      resn = 1'b0;
      model_reset();
      @(negedge clk);
      check("midrst_rspv", {rsp_valid_s, rsp_valid_w}, 0);
      @(negedge clk);
      resn = 1'b1;
      for (int k = 0; k < LAT + 2; k++) begin
         mac_rdata = {4{32'd999}};
         @(negedge clk);
         check("midrst_norsp", {rsp_valid_s, rsp_valid_w}, 0);
         check("midrst_ready", {ready_s, ready_w}, 2'b11);
      end
      do_cmd(3'd3, 32'd0, 32'd0, 4'd7, 32'd0, os, ow);
      check("midrst_acc", os, 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 80; n++) begin
         int          r;
         logic [2:0]  op;
         logic [31:0] addr, data, sl;
         r    = int'($urandom_range(0, 9));
         op   = (r < 2) ? 3'd0 : (r < 5) ? 3'd1 : (r < 7) ? 3'd2 :
                (r == 7) ? 3'd3 : (r == 8) ? 3'd4 : 3'($urandom_range(5, 7));
         addr = {$urandom} & 32'hFFFF_FF03;
         data = $urandom;
         if (op == 3'd4 && $urandom_range(0, 3) != 0) data[0] = 1'b0;
         sl   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
         do_cmd(op, addr, data, 4'($urandom_range(0, 3)), sl, os, ow);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
